slot_reels: RTL and testbench
=============================

# slot_reels

Multi-reel slot-machine core: NUM_REELS independent W-bit maximal-length LFSR reels that spin together on a step strobe and stop one at a time, left to right, after a stop request. It sits between the clock divider (source of `step`) and the seven-segment/LED display logic. It supersedes the single 4-bit slot register. It adds a game FSM, a minimum spin time, staggered reel stops, and win detection.

## Interface
Parameters:
- NUM_REELS, 3: reel count, 2..8.
- W, 4: reel width in bits, 3..8.
- SEED, 11: base seed, must be nonzero.
- MIN_SPIN, 8: minimum steps in SPIN before a stop is honoured, ≥1.
- STOP_GAP, 4: steps between successive reel freezes, ≥1.
- MAX_SPIN, 64: auto-stop step count, used only with SLOT_REELS_AUTOSTOP_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  one-clk advance strobe from the divider.
- start  in  1  pulse; begins a game.
- stop  in  1  pulse; requests reel stop.
- reels  out  NUM_REELS*W  reel i at bits [i*W +: W].
- stopped  out  NUM_REELS  bit i=1 means reel i is frozen.
- busy  out  1  high in SPIN and STOPPING.
- done  out  1  one-clk pulse when the last reel freezes.
- win  out  1  all reels equal; updated with done, held until next start.

## Operation
- Reel update on advance: next = {^(r & TAP_MASK[W]), r[W-1:1]} (right shift, feedback into MSB). The period is 2^W−1. For W=4, TAP_MASK=4'b0011.
- Reel i reset value: (SEED + i) mod 2^W, forced to 1 if the result is 0. A reel never holds 0.
- Reel i advances on a clk edge only when step=1, state ∈ {SPIN, STOPPING}, and stopped[i]=0.
- FSM states:
  - IDLE: start → SPIN. On that edge, stopped ← 0, spin_cnt ← 0, win ← 0, pending ← 0.
  - SPIN: spin_cnt increments on each step, saturating at MIN_SPIN. A stop pulse sets pending. When pending=1 and spin_cnt ≥ MIN_SPIN, go to STOPPING. On that same edge, stopped[0] ← 1, reel 0 does not advance, idx ← 1, gap_cnt ← 0.
  - STOPPING: gap_cnt increments on each step. On the step that brings gap_cnt to STOP_GAP, stopped[idx] ← 1, reel idx does not advance on that edge, and gap_cnt ← 0. If idx = NUM_REELS−1 → DONE, else idx++.
  - DONE: one cycle. done=1, win ← (all reels equal), then IDLE.
- start is ignored outside IDLE. stop is ignored in IDLE, STOPPING and DONE. A stop arriving on the same cycle as start in IDLE is discarded.
- Reel values are retained across games; they are not reseeded on start.
- Reset (any state, asynchronous): reels = seeds, stopped = all ones, busy=0, done=0, win=0, state=IDLE, all counters 0, pending=0.

## Timing
- All outputs are registered. busy rises the clk after the start edge.
- With step held high: stop accepted at edge E → stopped[0]=1 after E. stopped[k] sets at edge E+k·STOP_GAP. done is high during the cycle after edge E+(NUM_REELS−1)·STOP_GAP. busy falls with done.
- Steps falling in DONE or IDLE have no effect.
- A stop arriving while spin_cnt < MIN_SPIN takes effect on the first step at which spin_cnt reaches MIN_SPIN.

## Configuration
- SLOT_REELS_AUTOSTOP_EN defined: in SPIN, if no stop has been received after MAX_SPIN steps, pending is set internally and the game proceeds exactly as for a user stop.
- Undefined: no timeout. The reels spin until stop. MAX_SPIN is unused and its counter is not synthesised.

## Structure
- Package slot_pkg contains:
  - the state enum typedef (IDLE, SPIN, STOPPING, DONE);
  - the function tap_mask(W) for W=3..8: 3'b011, 4'b0011, 5'b00101, 6'b000011, 7'b0000011, 8'b00011101;
  - the function seed_of(SEED, i, W).
- Sub-module lfsr_reel (params W, SEED_VAL; ports clk, rst, en, q): one reel. It is instantiated NUM_REELS times via generate.

## Test plan
- Reset with W=4, N=3, SEED=11 → reels = B, C, D; stopped=3'b111; busy=0; win=0.
- start, one step → busy=1, reels = 5, 6, E. Twelve further steps follow the LFSR sequence B→5→A→D→…, with period 15.
- step high; stop pulsed after 2 steps (MIN_SPIN=8) → stop is honoured at step 8. stopped bits go 001, 011, 111 at 4-step spacing. done is a single pulse.
- step gated to 1-in-3 cycles → stop intervals scale by 3. No reel advances in cycles with step low.
- Force equal reels by setting SEED and N=2 so both seeds are equal (SEED=15, W=4, seeds F and 1 are distinct → adjust to a check of win=0), and a seeded equal case → win=1 with done.
- rst asserted mid-STOPPING → immediate reset values. A later start runs a normal game. start during busy and stop in IDLE have no effect. With the macro defined and no stop, done occurs after MAX_SPIN + (N−1)·STOP_GAP steps.

Source files
------------

// File: rtl/slot_reels_pkg.sv
// ---------------------------------------------------------------------------
// slot_pkg -- shared types and helpers for the slot_reels block.
//
// Contents:
//   state_t   game FSM states (IDLE, SPIN, STOPPING, DONE)
//   tap_mask  feedback tap mask for a maximal-length W-bit reel, W = 3..8
//   seed_of   reset value of reel i: (seed + i) mod 2^w, never zero
// ---------------------------------------------------------------------------
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        STOPPING,
        DONE
    } state_t;

    // Taps are applied to the current value; the XOR of the selected bits
    // is shifted into the MSB while the register shifts right.
    function automatic logic [7:0] tap_mask(input int w);
        case (w)
            3:       return 8'b0000_0011;
            4:       return 8'b0000_0011;
            5:       return 8'b0000_0101;
            6:       return 8'b0000_0011;
            7:       return 8'b0000_0011;
            8:       return 8'b0001_1101;
            default: return 8'b0000_0011;
        endcase
    endfunction

    // An LFSR stuck at zero never leaves it, so a zero seed is bumped to 1.
    function automatic int seed_of(input int seed, input int i, input int w);
        int v;
        v = (seed + i) % (1 << w);
        if (v == 0) begin
            v = 1;
        end
        return v;
    endfunction

endpackage

// File: rtl/slot_reels_lfsr_reel.sv
// ---------------------------------------------------------------------------
// lfsr_reel -- one W-bit maximal-length LFSR reel.
//
// Parameters: W (3..8), SEED_VAL (nonzero reset value)
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset, loads SEED_VAL
//   en   in   advance the reel by one position on this edge
//   q    out  current reel value (never zero)
// ---------------------------------------------------------------------------
module lfsr_reel
    import slot_pkg::*;
#(
    parameter int W        = 4,
    parameter int SEED_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [7:0]   TAPS_ALL = tap_mask(W);
    localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];
    localparam logic [W-1:0] SEED_W   = SEED_VAL[W-1:0];

    // Right shift with the tap parity fed into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED_W;
        end else if (en) begin
            q <= {^(q & TAPS), q[W-1:1]};
        end
    end

endmodule

// File: rtl/slot_reels.sv
// ---------------------------------------------------------------------------
// slot_reels -- multi-reel slot-machine core.
//
// NUM_REELS LFSR reels spin together on the step strobe; after a stop
// request (honoured only once MIN_SPIN steps have elapsed) they freeze one
// at a time, left to right, STOP_GAP steps apart. When the last reel
// freezes, done pulses and win reports whether all reels show the same value.
//
// Optional feature macro: SLOT_REELS_AUTOSTOP_EN -- when defined, a game with
// no stop request after MAX_SPIN steps stops itself.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   step     in   one-clk advance strobe
//   start    in   begin a game (IDLE only)
//   stop     in   request reel stop (SPIN only)
//   reels    out  reel i at bits [i*W +: W]
//   stopped  out  bit i set when reel i is frozen
//   busy     out  high in SPIN and STOPPING
//   done     out  one-clk pulse when the last reel freezes
//   win      out  all reels equal; valid with done, held until next start
// ---------------------------------------------------------------------------
module slot_reels
    import slot_pkg::*;
#(
    parameter int NUM_REELS = 3,
    parameter int W         = 4,
    parameter int SEED      = 11,
    parameter int MIN_SPIN  = 8,
    parameter int STOP_GAP  = 4,
    parameter int MAX_SPIN  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step,
    input  logic                   start,
    input  logic                   stop,
    output logic [NUM_REELS*W-1:0] reels,
    output logic [NUM_REELS-1:0]   stopped,
    output logic                   busy,
    output logic                   done,
    output logic                   win
);

    localparam int SW = $clog2(MIN_SPIN + 1);
    localparam int GW = $clog2(STOP_GAP + 1);
    localparam int IW = $clog2(NUM_REELS);
    localparam logic [SW-1:0] MIN_SPIN_C = SW'(MIN_SPIN);
    localparam logic [GW-1:0] STOP_GAP_C = GW'(STOP_GAP);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REELS - 1);

    // An out-of-range parameter set elaborates this empty marker block,
    // which makes the misconfiguration visible in the hierarchy.
    if (NUM_REELS < 2 || NUM_REELS > 8 || W < 3 || W > 8 || SEED == 0 ||
        MIN_SPIN < 1 || STOP_GAP < 1 || MAX_SPIN < 1) begin : g_param_out_of_range
    end

    state_t               state, state_d;
    logic [NUM_REELS-1:0] stopped_q, stopped_d;
    logic [NUM_REELS-1:0] freeze;
    logic [NUM_REELS-1:0] reel_en;
    logic [SW-1:0]        spin_cnt, spin_cnt_d;
    logic [GW-1:0]        gap_cnt, gap_cnt_d;
    logic [IW-1:0]        idx, idx_d;
    logic                 pending, pending_d;
    logic                 win_q, win_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 active;
    logic                 all_equal;
    logic [W-1:0]         reel_val [NUM_REELS];

`ifdef SLOT_REELS_AUTOSTOP_EN
    localparam int MW = $clog2(MAX_SPIN + 1);
    localparam logic [MW-1:0] MAX_SPIN_C = MW'(MAX_SPIN);
    logic [MW-1:0] max_cnt, max_cnt_d;
`endif

    assign active  = (state == SPIN) || (state == STOPPING);
    // A reel being frozen on this edge must not also advance on it.
    assign reel_en = {NUM_REELS{step & active}} & ~stopped_q & ~freeze;

    genvar i;
    for (i = 0; i < NUM_REELS; i++) begin : g_reel
        lfsr_reel #(
            .W        (W),
            .SEED_VAL (seed_of(SEED, i, W))
        ) u_reel (
            .clk (clk),
            .rst (rst),
            .en  (reel_en[i]),
            .q   (reel_val[i])
        );
        assign reels[i*W +: W] = reel_val[i];
    end

    // Win compare; sampled on the edge that freezes the last reel, when
    // every other reel is already still and the last one holds its value.
    always_comb begin
        all_equal = 1'b1;
        for (int k = 1; k < NUM_REELS; k++) begin
            if (reel_val[k] != reel_val[0]) begin
                all_equal = 1'b0;
            end
        end
    end

    // Next-state and next-counter logic for the game FSM. The SPIN exit
    // looks at the updated counter and pending flag so that an early stop
    // is honoured on the very step that completes the minimum spin.
    always_comb begin
        state_d    = state;
        stopped_d  = stopped_q;
        spin_cnt_d = spin_cnt;
        gap_cnt_d  = gap_cnt;
        idx_d      = idx;
        pending_d  = pending;
        win_d      = win_q;
        freeze     = '0;
`ifdef SLOT_REELS_AUTOSTOP_EN
        max_cnt_d  = max_cnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = SPIN;
                    stopped_d  = '0;
                    spin_cnt_d = '0;
                    gap_cnt_d  = '0;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    win_d      = 1'b0;
`ifdef SLOT_REELS_AUTOSTOP_EN
                    max_cnt_d  = '0;
`endif
                end
            end
            SPIN: begin
                if (step && spin_cnt != MIN_SPIN_C) begin
                    spin_cnt_d = spin_cnt + SW'(1);
                end
                if (stop) begin
                    pending_d = 1'b1;
                end
`ifdef SLOT_REELS_AUTOSTOP_EN
                if (step && max_cnt != MAX_SPIN_C) begin
                    max_cnt_d = max_cnt + MW'(1);
                end
                if (max_cnt_d == MAX_SPIN_C) begin
                    pending_d = 1'b1;
                end
`endif
                if (pending_d && spin_cnt_d == MIN_SPIN_C) begin
                    state_d      = STOPPING;
                    stopped_d[0] = 1'b1;
                    freeze[0]    = 1'b1;
                    idx_d        = IW'(1);
                    gap_cnt_d    = '0;
                end
            end
            STOPPING: begin
                if (step) begin
                    if (gap_cnt + GW'(1) == STOP_GAP_C) begin
                        gap_cnt_d        = '0;
                        stopped_d[idx]   = 1'b1;
                        freeze[idx]      = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_d = DONE;
                            win_d   = all_equal;
                        end else begin
                            idx_d = idx + IW'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt + GW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and done are registered from the next state so they line up
    // exactly with the state they describe.
    assign busy_d = (state_d == SPIN) || (state_d == STOPPING);
    assign done_d = (state_d == DONE);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stopped_q <= '1;
            spin_cnt  <= '0;
            gap_cnt   <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            win_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SLOT_REELS_AUTOSTOP_EN
            max_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            stopped_q <= stopped_d;
            spin_cnt  <= spin_cnt_d;
            gap_cnt   <= gap_cnt_d;
            idx       <= idx_d;
            pending   <= pending_d;
            win_q     <= win_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SLOT_REELS_AUTOSTOP_EN
            max_cnt   <= max_cnt_d;
`endif
        end
    end

    assign stopped = stopped_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;

endmodule

// File: tb/tb_slot_reels.sv
// ---------------------------------------------------------------------------
// tb_slot_reels -- self-checking bench for slot_reels.
// Main instance: NUM_REELS=3, W=4, SEED=11, MIN_SPIN=8, STOP_GAP=4.
// Second instance: NUM_REELS=2, W=4, SEED=11, MIN_SPIN=3, STOP_GAP=2, whose
// seeds B and C sit exactly two positions apart, so every game ends in a win.
// ---------------------------------------------------------------------------
module tb_slot_reels;

    localparam int N        = 3;
    localparam int W        = 4;
    localparam int MIN_SPIN = 8;
    localparam int STOP_GAP = 4;
    localparam int MAX_SPIN = 64;
    localparam int PERIOD   = 15;
    localparam int MAXC     = 300;

    logic           clk = 1'b0;
    logic           rst;
    logic           step, start, stop;
    logic [N*W-1:0] reels;
    logic [N-1:0]   stopped;
    logic           busy, done, win;

    logic           step2, start2, stop2;
    logic [7:0]     reels2;
    logic [1:0]     stopped2;
    logic           busy2, done2, win2;

    int checks = 0;
    int errors = 0;
    int seqv [PERIOD];
    int pos [N];

    typedef struct {
        logic        start;
        logic        stop;
        logic        step;
        logic [17:0] expv;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    slot_reels #(
        .NUM_REELS (N),
        .W         (W),
        .SEED      (11),
        .MIN_SPIN  (MIN_SPIN),
        .STOP_GAP  (STOP_GAP),
        .MAX_SPIN  (MAX_SPIN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .start   (start),
        .stop    (stop),
        .reels   (reels),
        .stopped (stopped),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    slot_reels #(
        .NUM_REELS (2),
        .W         (4),
        .SEED      (11),
        .MIN_SPIN  (3),
        .STOP_GAP  (2),
        .MAX_SPIN  (64)
    ) dut_win (
        .clk     (clk),
        .rst     (rst),
        .step    (step2),
        .start   (start2),
        .stop    (stop2),
        .reels   (reels2),
        .stopped (stopped2),
        .busy    (busy2),
        .done    (done2),
        .win     (win2)
    );

    // Observed outputs of the main instance packed as {reels, stopped, busy, done, win}
    function automatic logic [31:0] obs();
        return 32'({reels, stopped, busy, done, win});
    endfunction

    function automatic logic [31:0] obs2();
        return 32'({reels2, stopped2, busy2, done2, win2});
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive inputs for the coming edge, then sample 1 ns after it
    task automatic applyStimulus(input logic s, input logic sp, input logic st);
        start = s;
        stop  = sp;
        step  = st;
        @(posedge clk);
        #1;
    endtask

    // Whole-game reference: the honour edge, the freeze edge of every reel and
    // the final values are derived from counting steps in the input schedule.
    task automatic runGame(input int g, input int mode, input int stopA, input int stopB, input bit useStops);
        bit             stepS [MAXC];
        bit             stopS [MAXC];
        int             fr [N];
        int             adv [N];
        int             cur [N];
        int             steps, gapSteps, eh, lastF, v0;
        bit             seen, expWin;
        logic [N*W-1:0] er;
        logic [N-1:0]   es;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       stepS[c] = 1'b1;
                1:       stepS[c] = (c % 3 == 0);
                default: stepS[c] = 1'($urandom_range(0, 1));
            endcase
            stopS[c] = useStops && (c == stopA || c == stopB);
        end
        steps = 0;
        seen  = 1'b0;
        eh    = -1;
        for (int c = 1; c < MAXC && eh < 0; c++) begin
            if (stepS[c]) steps++;
            if (stopS[c]) seen = 1'b1;
`ifdef SLOT_REELS_AUTOSTOP_EN
            if (steps >= MAX_SPIN) seen = 1'b1;
`endif
            if (seen && steps >= MIN_SPIN) eh = c;
        end
        for (int i = 0; i < N; i++) fr[i] = -1;
        fr[0] = eh;
        if (eh >= 0) begin
            gapSteps = 0;
            for (int c = eh + 1; c < MAXC && fr[N-1] < 0; c++) begin
                if (stepS[c]) begin
                    gapSteps++;
                    if (gapSteps % STOP_GAP == 0) fr[gapSteps / STOP_GAP] = c;
                end
            end
        end
        if (fr[N-1] < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL game%0d schedule: no game end within %0d cycles", g, MAXC);
            return;
        end
        lastF = fr[N-1];
        for (int i = 0; i < N; i++) begin
            adv[i] = 0;
            cur[i] = 0;
            for (int c = 1; c < fr[i]; c++) if (stepS[c]) adv[i]++;
        end
        v0     = seqv[(pos[0] + adv[0]) % PERIOD];
        expWin = 1'b1;
        for (int i = 1; i < N; i++) begin
            if (seqv[(pos[i] + adv[i]) % PERIOD] != v0) expWin = 1'b0;
        end
        for (int c = 0; c <= lastF + 2; c++) begin
            applyStimulus(c == 0, stopS[c], stepS[c]);
            for (int i = 0; i < N; i++) begin
                if (c >= 1 && c < fr[i] && stepS[c]) cur[i]++;
                es[i]         = (c >= fr[i]);
                er[i*W +: W]  = 4'(seqv[(pos[i] + cur[i]) % PERIOD]);
            end
            checkOutput($sformatf("game%0d_cycle%0d", g, c), obs(),
                        32'({er, es, c < lastF, c == lastF, (c >= lastF) && expWin}));
        end
        for (int i = 0; i < N; i++) pos[i] = (pos[i] + adv[i]) % PERIOD;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v, fb;
        // Reel sequence starting from B, built from the feedback rule with taps 4'b0011
        v = 11;
        for (int k = 0; k < PERIOD; k++) begin
            seqv[k] = v;
            fb      = $countones(v & 3) & 1;
            v       = (fb << 3) | (v >> 1);
        end

        tbl[0] = '{start: 1'b1, stop: 1'b0, step: 1'b0, expv: {12'hDCB, 3'b000, 3'b100}};
        tbl[1] = '{start: 1'b0, stop: 1'b0, step: 1'b1, expv: {12'hE65, 3'b000, 3'b100}};
        tbl[2] = '{start: 1'b0, stop: 1'b0, step: 1'b1, expv: {12'hFBA, 3'b000, 3'b100}};
        tbl[3] = '{start: 1'b0, stop: 1'b0, step: 1'b0, expv: {12'hFBA, 3'b000, 3'b100}};
        tbl[4] = '{start: 1'b1, stop: 1'b0, step: 1'b0, expv: {12'hFBA, 3'b000, 3'b100}};
        tbl[5] = '{start: 1'b0, stop: 1'b0, step: 1'b1, expv: {12'h75D, 3'b000, 3'b100}};
        tbl[6] = '{start: 1'b0, stop: 1'b0, step: 1'b1, expv: {12'h3AE, 3'b000, 3'b100}};

        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        step   = 1'b0;
        start2 = 1'b0;
        stop2  = 1'b0;
        step2  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", obs(), 32'({12'hDCB, 3'b111, 3'b000}));
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idleStepIgnored", obs(), 32'({12'hDCB, 3'b111, 3'b000}));

        // Start, first steps along the sequence, start while busy ignored
        for (int t = 0; t < 7; t++) begin
            applyStimulus(tbl[t].start, tbl[t].stop, tbl[t].step);
            checkOutput($sformatf("vector%0d", t), obs(), 32'(tbl[t].expv));
        end

        // Stop on step 5 is held until step 8, then reels freeze 4 steps apart
        for (int s = 5; s <= 16; s++) begin
            applyStimulus(1'b0, s == 5, 1'b1);
            checkOutput($sformatf("stagger_step%0d", s), 32'({stopped, busy, done}),
                        32'({(s >= 16) ? 3'b111 : (s >= 12) ? 3'b011 : (s >= 8) ? 3'b001 : 3'b000,
                             s < 16, s == 16}));
        end
        checkOutput("staggerFinalReels", 32'(reels), 32'(12'hD83));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("doneSinglePulse", obs(), 32'({12'hD83, 3'b111, 3'b000}));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stopInIdle", obs(), 32'({12'hD83, 3'b111, 3'b000}));
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stopInIdleNoGame", obs(), 32'({12'hD83, 3'b111, 3'b000}));
        pos = '{7, 9, 3};

        // Randomised games: every step, 1-in-3 steps, random steps
        for (int g = 0; g < 9; g++) begin
            runGame(g, g % 3, $urandom_range(0, 30), $urandom_range(1, 30), 1'b1);
        end

        // Reset while STOPPING returns everything to reset values at once
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 20 && stopped[0] !== 1'b1; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("honourBeforeReset", 32'({busy, stopped}), 32'({1'b1, 3'b001}));
        applyStimulus(1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetMidStopping", obs(), 32'({12'hDCB, 3'b111, 3'b000}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("afterResetRelease", obs(), 32'({12'hDCB, 3'b111, 3'b000}));
        pos = '{0, 13, 3};
        runGame(100, 2, $urandom_range(1, 30), $urandom_range(1, 30), 1'b1);

`ifdef SLOT_REELS_AUTOSTOP_EN
        // No stop at all: the game ends MAX_SPIN + (N-1)*STOP_GAP steps after start
        runGame(200, 0, 0, 0, 1'b0);
`endif

        // Second instance: seeds two positions apart produce a guaranteed win
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        step2  = 1'b1;
        stop2  = 1'b1;
        @(posedge clk);
        #1;
        stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("win2BeforeLast", obs2(), 32'({8'hAA, 2'b01, 3'b100}));
        @(posedge clk);
        #1;
        checkOutput("win2WithDone", obs2(), 32'({8'hAA, 2'b11, 3'b011}));
        @(posedge clk);
        #1;
        checkOutput("win2Held", obs2(), 32'({8'hAA, 2'b11, 3'b001}));
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        step2  = 1'b0;
        checkOutput("win2ClearedOnStart", obs2(), 32'({8'hAA, 2'b00, 3'b100}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
